minirisc_bus_arbiter: RTL and testbench

//   Two-master arbiter for the MiniRISC data-memory bus. It sits directly downstream of the CPU's master bus interface.
//   - Master 0 (M0): the MiniRISC CPU (m_bus_req / m_bus_grant).
//   - Master 1 (M1): a DMA or peripheral master.

---
 rtl/minirisc_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_minirisc_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minirisc_bus_arbiter.sv
// Two-master arbiter for the MiniRISC data-memory bus. It grants one master at a time and muxes that master onto the slave bus.
// Build option: define MINIRISC_ARB_RR_EN for round-robin ties. Left undefined, M0 (the CPU) wins every tie.
module minirisc_bus_arbiter #(
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_bus_req,
  output logic       m0_bus_grant,
  input  logic [7:0] m0_mst2slv_addr,
  input  logic       m0_mst2slv_wr,
  input  logic       m0_mst2slv_rd,
  input  logic [7:0] m0_mst2slv_data,
  output logic [7:0] m0_slv2mst_data,
  input  logic       m1_bus_req,
  output logic       m1_bus_grant,
  input  logic [7:0] m1_mst2slv_addr,
  input  logic       m1_mst2slv_wr,
  input  logic       m1_mst2slv_rd,
  input  logic [7:0] m1_mst2slv_data,
  output logic [7:0] m1_slv2mst_data,
  output logic [7:0] s_mst2slv_addr,
  output logic       s_mst2slv_wr,
  output logic       s_mst2slv_rd,
  output logic [7:0] s_mst2slv_data,
  input  logic [7:0] s_slv2mst_data,
  output logic       bus_timeout,
  output logic [1:0] active_mst
);

  // Request/grant handshake: a master holds req high for its whole tenure. The grant is
  // registered and rises the cycle after req is sampled high. The master owns the slave
  // bus only while its grant is high. Dropping req releases the bus at the next edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

  localparam bit               LP_WD_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] LP_LAST_CNT = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mask;
  logic             r_timeout;
  logic             w_req0_ok;
  logic             w_req1_ok;
  logic             w_pick1;
  logic             w_expire;
  logic             w_wd_release;

  assign w_req0_ok = m0_bus_req & ~r_mask[0];
  assign w_req1_ok = m1_bus_req & ~r_mask[1];
  assign w_expire  = LP_WD_EN && (r_cnt == LP_LAST_CNT);

`ifdef MINIRISC_ARB_RR_EN
  // r_last: 0 = M0 was granted most recently, 1 = M1.
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_GNT0) begin
      r_last <= 1'b0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_GNT1) begin
      r_last <= 1'b1;
    end
  end

  assign w_pick1 = ~r_last;
`else
  assign w_pick1 = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_wd_release = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req0_ok && w_req1_ok) w_state_nxt = w_pick1 ? ST_GNT1 : ST_GNT0;
        else if (w_req0_ok)         w_state_nxt = ST_GNT0;
        else if (w_req1_ok)         w_state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0_bus_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_state_nxt  = ST_IDLE;
          w_wd_release = 1'b1;
        end
      end
      ST_GNT1: begin
        if (!m1_bus_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_state_nxt  = ST_IDLE;
          w_wd_release = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mask    <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_wd_release;
      // The counter is held at zero while idle, so every tenure starts counting from zero.
      if (r_state == ST_IDLE)        r_cnt <= '0;
      else if (r_cnt != LP_CNT_MAX)  r_cnt <= r_cnt + 1'b1;
      // A master released by the watchdog stays masked until it drops its request.
      r_mask[0] <= (r_mask[0] & m0_bus_req) | (w_wd_release & (r_state == ST_GNT0));
      r_mask[1] <= (r_mask[1] & m1_bus_req) | (w_wd_release & (r_state == ST_GNT1));
    end
  end

  assign m0_bus_grant    = (r_state == ST_GNT0);
  assign m1_bus_grant    = (r_state == ST_GNT1);
  assign active_mst      = {m1_bus_grant, m0_bus_grant};
  assign bus_timeout     = r_timeout;
  assign m0_slv2mst_data = s_slv2mst_data;
  assign m1_slv2mst_data = s_slv2mst_data;

  always_comb begin
    s_mst2slv_addr = 8'h00;
    s_mst2slv_wr   = 1'b0;
    s_mst2slv_rd   = 1'b0;
    s_mst2slv_data = 8'h00;
    case (r_state)
      ST_GNT0: begin
        s_mst2slv_addr = m0_mst2slv_addr;
        s_mst2slv_wr   = m0_mst2slv_wr;
        s_mst2slv_rd   = m0_mst2slv_rd;
        s_mst2slv_data = m0_mst2slv_data;
      end
      ST_GNT1: begin
        s_mst2slv_addr = m1_mst2slv_addr;
        s_mst2slv_wr   = m1_mst2slv_wr;
        s_mst2slv_rd   = m1_mst2slv_rd;
        s_mst2slv_data = m1_mst2slv_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minirisc_bus_arbiter.sv
// Bench for minirisc_bus_arbiter built with an 8-cycle watchdog. It compares the design against a
// tenure/owner model on every cycle and also runs directed scenarios with literal expectations.
module tb_minirisc_bus_arbiter;

  localparam int TMO = 8;

  logic       clk;
  logic       rst;
  logic       m0_bus_req, m1_bus_req;
  logic       m0_bus_grant, m1_bus_grant;
  logic [7:0] m0_mst2slv_addr, m1_mst2slv_addr;
  logic       m0_mst2slv_wr, m1_mst2slv_wr;
  logic       m0_mst2slv_rd, m1_mst2slv_rd;
  logic [7:0] m0_mst2slv_data, m1_mst2slv_data;
  logic [7:0] m0_slv2mst_data, m1_slv2mst_data;
  logic [7:0] s_mst2slv_addr;
  logic       s_mst2slv_wr;
  logic       s_mst2slv_rd;
  logic [7:0] s_mst2slv_data;
  logic [7:0] s_slv2mst_data;
  logic       bus_timeout;
  logic [1:0] active_mst;

  minirisc_bus_arbiter #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .m0_bus_req      (m0_bus_req),
    .m0_bus_grant    (m0_bus_grant),
    .m0_mst2slv_addr (m0_mst2slv_addr),
    .m0_mst2slv_wr   (m0_mst2slv_wr),
    .m0_mst2slv_rd   (m0_mst2slv_rd),
    .m0_mst2slv_data (m0_mst2slv_data),
    .m0_slv2mst_data (m0_slv2mst_data),
    .m1_bus_req      (m1_bus_req),
    .m1_bus_grant    (m1_bus_grant),
    .m1_mst2slv_addr (m1_mst2slv_addr),
    .m1_mst2slv_wr   (m1_mst2slv_wr),
    .m1_mst2slv_rd   (m1_mst2slv_rd),
    .m1_mst2slv_data (m1_mst2slv_data),
    .m1_slv2mst_data (m1_slv2mst_data),
    .s_mst2slv_addr  (s_mst2slv_addr),
    .s_mst2slv_wr    (s_mst2slv_wr),
    .s_mst2slv_rd    (s_mst2slv_rd),
    .s_mst2slv_data  (s_mst2slv_data),
    .s_slv2mst_data  (s_slv2mst_data),
    .bus_timeout     (bus_timeout),
    .active_mst      (active_mst)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 M0, 2 M1. held = grant cycles used by the current owner, including the present one.
  int mdl_owner = 0;
  int mdl_held  = 0;
  int mdl_last  = 2;
  bit mdl_mask0 = 1'b0;
  bit mdl_mask1 = 1'b0;
  bit mdl_pulse = 1'b0;
  bit rq0, rq1, el0, el1, own_req;
  int win;

  always @(posedge clk) begin
    rq0 = m0_bus_req;
    rq1 = m1_bus_req;
    if (rst) begin
      mdl_owner = 0; mdl_held = 0; mdl_last = 2;
      mdl_mask0 = 1'b0; mdl_mask1 = 1'b0; mdl_pulse = 1'b0;
    end else begin
      mdl_pulse = 1'b0;
      if (mdl_owner == 0) begin
        el0 = rq0 && !mdl_mask0;
        el1 = rq1 && !mdl_mask1;
        win = 0;
        if (el0 && el1) begin
`ifdef MINIRISC_ARB_RR_EN
          win = (mdl_last == 1) ? 2 : 1;
`else
          win = 1;
`endif
        end else if (el0) win = 1;
        else if (el1)     win = 2;
        if (win != 0) begin
          mdl_owner = win; mdl_held = 1; mdl_last = win;
        end
      end else begin
        own_req = (mdl_owner == 1) ? rq0 : rq1;
        if (!own_req) begin
          mdl_owner = 0;
        end else if (TMO != 0 && mdl_held == TMO) begin
          if (mdl_owner == 1) mdl_mask0 = 1'b1;
          else                mdl_mask1 = 1'b1;
          mdl_owner = 0;
          mdl_pulse = 1'b1;
        end else begin
          mdl_held++;
        end
      end
      if (!rq0) mdl_mask0 = 1'b0;
      if (!rq1) mdl_mask1 = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] e_addr, e_data;
  logic       e_wr, e_rd;

  always @(negedge clk) begin
    if (chk_en) begin
      e_addr = 8'h00; e_data = 8'h00; e_wr = 1'b0; e_rd = 1'b0;
      if (mdl_owner == 1) begin
        e_addr = m0_mst2slv_addr; e_data = m0_mst2slv_data; e_wr = m0_mst2slv_wr; e_rd = m0_mst2slv_rd;
      end else if (mdl_owner == 2) begin
        e_addr = m1_mst2slv_addr; e_data = m1_mst2slv_data; e_wr = m1_mst2slv_wr; e_rd = m1_mst2slv_rd;
      end
      check("cmp_grant0", 32'(m0_bus_grant), 32'(mdl_owner == 1));
      check("cmp_grant1", 32'(m1_bus_grant), 32'(mdl_owner == 2));
      check("cmp_active", 32'(active_mst), 32'(mdl_owner));
      check("cmp_timeout", 32'(bus_timeout), 32'(mdl_pulse));
      check("cmp_s_addr", 32'(s_mst2slv_addr), 32'(e_addr));
      check("cmp_s_data", 32'(s_mst2slv_data), 32'(e_data));
      check("cmp_s_wr", 32'(s_mst2slv_wr), 32'(e_wr));
      check("cmp_s_rd", 32'(s_mst2slv_rd), 32'(e_rd));
      check("cmp_rd0", 32'(m0_slv2mst_data), 32'(s_slv2mst_data));
      check("cmp_rd1", 32'(m1_slv2mst_data), 32'(s_slv2mst_data));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_bus_req = 1'b0; m0_mst2slv_addr = 8'h00; m0_mst2slv_wr = 1'b0;
    m0_mst2slv_rd = 1'b0; m0_mst2slv_data = 8'h00;
    m1_bus_req = 1'b0; m1_mst2slv_addr = 8'h00; m1_mst2slv_wr = 1'b0;
    m1_mst2slv_rd = 1'b0; m1_mst2slv_data = 8'h00;
    s_slv2mst_data = 8'h00;
  endtask

  // ---------------- stimulus ----------------
  int w, w2;

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset held with both masters requesting.
    m0_bus_req = 1'b1; m1_bus_req = 1'b1; m0_mst2slv_addr = 8'h11; m0_mst2slv_wr = 1'b1;
    next_edge();
    chk_en = 1'b1;
    next_edge();
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    check("rst_grant0", 32'(m0_bus_grant), 32'd0);
    check("rst_grant1", 32'(m1_bus_grant), 32'd0);
    check("rst_active", 32'(active_mst), 32'd0);
    check("rst_s_addr", 32'(s_mst2slv_addr), 32'd0);
    check("rst_s_wr", 32'(s_mst2slv_wr), 32'd0);
    next_edge();
    @(negedge clk);
    check("post_rst_grant0", 32'(m0_bus_grant), 32'd1);
    check("post_rst_active", 32'(active_mst), 32'd1);
    next_edge();
    clear_inputs();
    next_edge();
    @(negedge clk);
    check("drop_grant0", 32'(m0_bus_grant), 32'd0);
    check("drop_grant1", 32'(m1_bus_grant), 32'd0);

    // Single master write, plus the read-data broadcast.
    next_edge();
    m0_bus_req = 1'b1; m0_mst2slv_addr = 8'h3C; m0_mst2slv_wr = 1'b1; m0_mst2slv_data = 8'hA5;
    s_slv2mst_data = 8'h5A;
    next_edge();
    @(negedge clk);
    check("single_grant0", 32'(m0_bus_grant), 32'd1);
    check("single_s_addr", 32'(s_mst2slv_addr), 32'h3C);
    check("single_s_wr", 32'(s_mst2slv_wr), 32'd1);
    check("single_s_data", 32'(s_mst2slv_data), 32'hA5);
    check("read_m0", 32'(m0_slv2mst_data), 32'h5A);
    check("read_m1", 32'(m1_slv2mst_data), 32'h5A);
    next_edge();
    m0_bus_req = 1'b0;
    next_edge();
    @(negedge clk);
    check("single_release", 32'(m0_bus_grant), 32'd0);
    check("single_s_addr0", 32'(s_mst2slv_addr), 32'd0);
    check("single_s_wr0", 32'(s_mst2slv_wr), 32'd0);
    next_edge();
    clear_inputs();

    // Ties. M0 was served last, so round-robin hands the first tie to M1.
`ifdef MINIRISC_ARB_RR_EN
    w = 2;
`else
    w = 1;
`endif
    m0_bus_req = 1'b1; m1_bus_req = 1'b1;
    next_edge();
    @(negedge clk);
    check("tie1_winner", 32'(active_mst), 32'(w));
    next_edge();
    if (w == 1) m0_bus_req = 1'b0; else m1_bus_req = 1'b0;
    next_edge();
    @(negedge clk);
    check("tie1_turnaround", 32'(active_mst), 32'd0);
    next_edge();
    @(negedge clk);
    check("tie1_other", 32'(active_mst), 32'(3 - w));
    next_edge();
    m0_bus_req = 1'b0; m1_bus_req = 1'b0;
    next_edge();
`ifdef MINIRISC_ARB_RR_EN
    w2 = w;
`else
    w2 = 1;
`endif
    m0_bus_req = 1'b1; m1_bus_req = 1'b1;
    next_edge();
    @(negedge clk);
    check("tie2_winner", 32'(active_mst), 32'(w2));
    next_edge();
    m0_bus_req = 1'b0; m1_bus_req = 1'b0;
    next_edge();
    next_edge();

    // Watchdog: M1 holds for 20 cycles, M0 arrives at cycle 3 and drops at cycle 13.
    for (int i = 0; i < 20; i++) begin
      if (i < TMO)                exp_q.push_back(2'b10);
      else if (i == TMO)          exp_q.push_back(2'b00);
      else if (i <= 12)           exp_q.push_back(2'b01);
      else                        exp_q.push_back(2'b00);
    end
    m1_bus_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      next_edge();
      if (i == 2)  m0_bus_req = 1'b1;
      if (i == 12) m0_bus_req = 1'b0;
      @(negedge clk);
      check("wd_grants", 32'(active_mst), 32'(exp_q.pop_front()));
      check("wd_pulse", 32'(bus_timeout), 32'(i == TMO));
    end
    next_edge();
    m1_bus_req = 1'b0;
    next_edge();
    m1_bus_req = 1'b1;
    next_edge();
    @(negedge clk);
    check("wd_unmask_regrant", 32'(m1_bus_grant), 32'd1);
    next_edge();
    m1_bus_req = 1'b0;
    next_edge();
    next_edge();

    // Request drop coincides with expiry: ordinary release, no pulse, no mask.
    m0_bus_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_edge();
      if (i == 7) m0_bus_req = 1'b0;
      if (i == 8) m0_bus_req = 1'b1;
      @(negedge clk);
      check("coinc_grant0", 32'(m0_bus_grant), 32'(i != 8));
      check("coinc_pulse", 32'(bus_timeout), 32'd0);
    end
    next_edge();
    m0_bus_req = 1'b0;
    next_edge();
    next_edge();

    // Reset during the 4th cycle of an M1 write tenure.
    m1_bus_req = 1'b1; m1_mst2slv_wr = 1'b1; m1_mst2slv_addr = 8'h77;
    for (int i = 0; i < 4; i++) begin
      next_edge();
      @(negedge clk);
      check("midrst_pre_grant1", 32'(m1_bus_grant), 32'd1);
    end
    rst = 1'b1;
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_grant1", 32'(m1_bus_grant), 32'd0);
    check("midrst_s_wr", 32'(s_mst2slv_wr), 32'd0);
    check("midrst_timeout", 32'(bus_timeout), 32'd0);
    check("midrst_active", 32'(active_mst), 32'd0);
    repeat (12) next_edge();
    clear_inputs();
    next_edge();

    // Random traffic with sticky requests so that tenures regularly reach the watchdog.
    for (int i = 0; i < 3000; i++) begin
      next_edge();
      if ($urandom_range(0, 9) < 2) m0_bus_req = ~m0_bus_req;
      if ($urandom_range(0, 9) < 2) m1_bus_req = ~m1_bus_req;
      m0_mst2slv_addr = 8'($urandom_range(0, 255));
      m0_mst2slv_data = 8'($urandom_range(0, 255));
      m0_mst2slv_wr   = 1'($urandom_range(0, 1));
      m0_mst2slv_rd   = 1'($urandom_range(0, 1));
      m1_mst2slv_addr = 8'($urandom_range(0, 255));
      m1_mst2slv_data = 8'($urandom_range(0, 255));
      m1_mst2slv_wr   = 1'($urandom_range(0, 1));
      m1_mst2slv_rd   = 1'($urandom_range(0, 1));
      s_slv2mst_data  = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 199) == 0);
    end
    next_edge();
    rst = 1'b0;
    clear_inputs();
    repeat (3) next_edge();
    @(negedge clk);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
